// File: rtl/prbs_pkg.sv
// Shared PRBS15 constants and state encoding, common to the stream generator and checker.
package prbs_pkg;

   localparam int unsigned PRBS_LEN = 15;
   localparam int unsigned TAP_A    = 14;
   localparam int unsigned TAP_B    = 15;

   typedef enum logic [1:0] {
      SEED,
      HUNT,
      LOCKED
   } prbs_state_t;

   // Next stream bit given the history register, r[1] being the newest bit.
   function automatic logic prbs_predict(input logic [PRBS_LEN:1] r);
      return r[TAP_A] ^ r[TAP_B];
   endfunction

endpackage

// File: rtl/prbs15_checker_if.sv
// Serial receive stream and integrity report between the link front end and the PRBS15 checker.
interface prbs15_checker_if #(
   parameter int unsigned ERR_CNT_W = 16
);

   logic                 enable;
   logic                 data_in;
   logic                 clear_errors;
   logic                 locked;
   logic                 error_pulse;
   logic [ERR_CNT_W-1:0] error_count;

   modport master (
      output enable, data_in, clear_errors,
      input  locked, error_pulse, error_count
   );

   modport slave (
      input  enable, data_in, clear_errors,
      output locked, error_pulse, error_count
   );

endinterface

// File: rtl/prbs_window_monitor.sv
// Counts errors within fixed-length windows of locked bits and flags loss of lock at the threshold.
module prbs_window_monitor #(
   parameter int unsigned WINDOW     = 64,
   parameter int unsigned ERR_THRESH = 8
) (
   input  logic clk,
   input  logic sync_reset_n,
   input  logic restart,
   input  logic bit_valid,
   input  logic bit_err,
   output logic lose_lock
);

   localparam int unsigned BW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam int unsigned EW = $clog2(WINDOW + 1);

   logic [BW-1:0] bit_cnt;
   logic [EW-1:0] err_cnt;
   logic [EW-1:0] err_cnt_n;
   logic          wrap;

   // The bit that wraps the counter opens the new window, so its error lands there.
   always_comb begin
      wrap      = (bit_cnt == BW'(WINDOW - 1));
      err_cnt_n = (wrap ? '0 : err_cnt) + EW'(bit_err);
      lose_lock = bit_valid && bit_err && (err_cnt_n >= EW'(ERR_THRESH));
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n || restart) begin
         bit_cnt <= '0;
         err_cnt <= '0;
      end else if (bit_valid) begin
         bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;
         err_cnt <= err_cnt_n;
      end
   end

endmodule

// File: rtl/prbs15_checker.sv
// Self-synchronising PRBS15 receiver: seeds from the stream, hunts for a clean run, then
// freewheels its own LFSR and counts received bit errors.
module prbs15_checker #(
   parameter int unsigned LOCK_COUNT = 32,
   parameter int unsigned WINDOW     = 64,
   parameter int unsigned ERR_THRESH = 8,
   parameter int unsigned ERR_CNT_W  = 16
) (
   input  logic             clk,
   input  logic             sync_reset_n,
   prbs15_checker_if.slave  bus
);

   import prbs_pkg::*;

   prbs_state_t         state, state_n;
   logic [PRBS_LEN:1]   r, r_n;
   logic [3:0]          seed_cnt, seed_cnt_n;
   logic [7:0]          match_cnt, match_cnt_n;
   logic                predict;
   logic                mismatch;
   logic                err_hit;
   logic                lose_lock;

   always_comb begin
      state_n     = state;
      r_n         = r;
      seed_cnt_n  = seed_cnt;
      match_cnt_n = match_cnt;
      err_hit     = 1'b0;
      predict     = prbs_predict(r);
      mismatch    = (bus.data_in != predict);

      if (bus.enable) begin
         unique case (state)
            SEED: begin
               r_n = {r[PRBS_LEN-1:1], bus.data_in};
               if (seed_cnt == 4'(PRBS_LEN - 1)) begin
                  state_n     = HUNT;
                  seed_cnt_n  = '0;
                  match_cnt_n = '0;
               end else begin
                  seed_cnt_n = seed_cnt + 4'd1;
               end
            end
            HUNT: begin
               r_n = {r[PRBS_LEN-1:1], bus.data_in};
               if (r == '0 || mismatch) begin
                  state_n    = SEED;
                  seed_cnt_n = '0;
               end else if (match_cnt == 8'(LOCK_COUNT - 1)) begin
                  state_n     = LOCKED;
                  match_cnt_n = '0;
               end else begin
                  match_cnt_n = match_cnt + 8'd1;
               end
            end
            LOCKED: begin
               // Freewheel on the prediction so line errors never enter the register.
               r_n     = {r[PRBS_LEN-1:1], predict};
               err_hit = mismatch;
               if (lose_lock) begin
                  state_n    = SEED;
                  seed_cnt_n = '0;
               end
            end
            default: state_n = SEED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         state           <= SEED;
         r               <= '0;
         seed_cnt        <= '0;
         match_cnt       <= '0;
         bus.locked      <= 1'b0;
         bus.error_pulse <= 1'b0;
         bus.error_count <= '0;
      end else begin
         state           <= state_n;
         r               <= r_n;
         seed_cnt        <= seed_cnt_n;
         match_cnt       <= match_cnt_n;
         bus.locked      <= (state_n == LOCKED);
         bus.error_pulse <= err_hit;
         if (bus.clear_errors)
            bus.error_count <= '0;
         else if (err_hit && bus.error_count != '1)
            bus.error_count <= bus.error_count + 1'b1;
      end
   end

   prbs_window_monitor #(
      .WINDOW     (WINDOW),
      .ERR_THRESH (ERR_THRESH)
   ) u_window (
      .clk          (clk),
      .sync_reset_n (sync_reset_n),
      .restart      (state != LOCKED),
      .bit_valid    (bus.enable && state == LOCKED),
      .bit_err      (mismatch),
      .lose_lock    (lose_lock)
   );

endmodule

// File: tb/tb_prbs15_checker.sv
// Directed scoreboard bench for prbs15_checker: expectations queued at drive time, checked by a monitor.
module tb_prbs15_checker;

   localparam int unsigned W       = 16;
   localparam int unsigned LOCK_AT = 47;

   logic clk = 1'b0;
   logic sync_reset_n;

   prbs15_checker_if #(.ERR_CNT_W(W)) bus ();

   prbs15_checker #(
      .LOCK_COUNT (32),
      .WINDOW     (64),
      .ERR_THRESH (8),
      .ERR_CNT_W  (W)
   ) dut (
      .clk          (clk),
      .sync_reset_n (sync_reset_n),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         locked;
      logic         pulse;
      logic [W-1:0] count;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:1] gen;
   int          acq;
   int          ecnt;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
      end
   endtask

   // Monitor: outputs are sampled 1 time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("locked", W'(bus.locked), W'(e.locked));
            chk("error_pulse", W'(bus.error_pulse), W'(e.pulse));
            chk("error_count", bus.error_count, e.count);
         end
      end
   end

   task automatic cycle(input logic rst_n, input logic en, input logic d, input logic clr,
                        input logic x_lock, input logic x_pulse, input int x_cnt);
      exp_t e;
      @(negedge clk);
      sync_reset_n     = rst_n;
      bus.enable       = en;
      bus.data_in      = d;
      bus.clear_errors = clr;
      e.locked = x_lock;
      e.pulse  = x_pulse;
      e.count  = W'(x_cnt);
      exp_q.push_back(e);
   endtask

   task automatic next_bit(output logic b);
      b   = gen[14] ^ gen[15];
      gen = {gen[14:1], b};
   endtask

   task automatic do_reset();
      acq  = 0;
      ecnt = 0;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   // One accepted stream bit; flip corrupts it, lose marks the bit that drops lock.
   task automatic send(input logic flip, input logic clr, input logic lose);
      logic b;
      next_bit(b);
      acq++;
      if (clr)       ecnt = 0;
      else if (flip) ecnt++;
      if (lose)      acq = 0;
      cycle(1'b1, 1'b1, b ^ flip, clr, (acq >= LOCK_AT), flip, ecnt);
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle();
      cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, (acq >= LOCK_AT), 1'b0, ecnt);
   endtask

   initial begin
      int en_bits;
      sync_reset_n     = 1'b0;
      bus.enable       = 1'b0;
      bus.data_in      = 1'b0;
      bus.clear_errors = 1'b0;
      gen              = 15'h7FFF;
      acq              = 0;
      ecnt             = 0;

      // Clean acquisition: lock visible right after the 47th bit.
      do_reset();
      do_reset();
      clean(200);

      // Single error while locked; freewheeling register keeps following bits clean.
      send(1'b1, 1'b0, 1'b0);
      clean(70);

      // Clear alone, then clear coinciding with an error.
      send(1'b0, 1'b1, 1'b0);
      clean(3);
      send(1'b1, 1'b1, 1'b0);
      clean(3);

      // Five spaced errors, then a one-cycle reset while locked.
      for (int k = 0; k < 5; k++) begin
         send(1'b1, 1'b0, 1'b0);
         clean(4);
      end
      do_reset();
      clean(LOCK_AT + 10);

      // Eight errors inside one window: the eighth drops lock and is counted.
      for (int k = 1; k <= 8; k++) begin
         send(1'b1, 1'b0, (k == 8));
         if (k < 8) clean(1);
      end
      clean(LOCK_AT + 5);

      // Constant-zero input never locks and never counts.
      do_reset();
      for (int i = 0; i < 500; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // ~30% enable duty on a clean stream: lock follows enabled bits only.
      do_reset();
      en_bits = 0;
      for (int i = 0; i < 2000 && en_bits < LOCK_AT + 15; i++) begin
         if ($urandom_range(0, 99) < 30) begin
            send(1'b0, 1'b0, 1'b0);
            en_bits++;
         end else begin
            idle();
         end
      end
      send(1'b1, 1'b1, 1'b0);
      idle();
      clean(2);

      @(negedge clk);
      bus.enable = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
